// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues ROM reads, buffers up to two fetched words and stops on a halt opcode.
// Optional FETCH_PERF_CNT_EN adds a 16-bit saturating stall counter output (stall_cnt).
module instruction_fetch #(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc,
    output logic        inc_en,
    output logic [7:0]  rom_addr,
    output logic        rom_rden,
    input  logic [31:0] rom_q,
    input  logic        flush,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [39:0] fifo_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        in_flight;
    logic [7:0]  tag;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  pending;

    // A read may issue only if its response is guaranteed a free slot when it lands.
    always_comb begin
        pop     = instr_valid & instr_ready;
        pending = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
        issue   = reset && (state == RUN) && !flush && (pending < 3'd2);
        push    = in_flight && (state == RUN) && !flush;
    end

    assign inc_en      = issue;
    assign rom_rden    = issue;
    assign rom_addr    = pc;
    assign instr_valid = (count != 2'd0);
    assign {instr, instr_pc} = fifo_mem[rd_ptr];
    assign halted      = (state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            in_flight   <= 1'b0;
            tag         <= 8'h00;
            fifo_mem[0] <= 40'h0;
            fifo_mem[1] <= 40'h0;
        end else if (flush) begin
            state     <= RUN;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                tag <= pc;
            end
            // Responses landing once HALT is reached are dropped because push requires RUN.
            if (push) begin
                fifo_mem[wr_ptr] <= {rom_q, tag};
                wr_ptr           <= ~wr_ptr;
                if (rom_q[31:26] == HALT_OPCODE) begin
                    state <= HALT;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'h0000;
        end else if (instr_valid && !instr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: PC/ROM environment model plus an in-order scoreboard.
// Build with FETCH_PERF_CNT_EN defined to also cover the stall counter.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc = 8'h00;
    logic        inc_en;
    logic [7:0]  rom_addr;
    logic        rom_rden;
    logic [31:0] rom_q = 32'h0;
    logic        flush;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic [31:0] rom [256];

    logic [39:0] sb [$];
    logic        halt_issued;
    int          halt_age;
    logic        prev_stall;
    logic [31:0] prev_word;
    logic [7:0]  prev_pc;

    int checks_total  = 0;
    int checks_passed = 0;

    instruction_fetch #(.HALT_OPCODE(6'h3F)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .inc_en      (inc_en),
        .rom_addr    (rom_addr),
        .rom_rden    (rom_rden),
        .rom_q       (rom_q),
        .flush       (flush),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Program counter stage and synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (pc_load) begin
            pc <= pc_load_val;
        end else if (inc_en) begin
            pc <= pc + 8'd1;
        end
        if (rom_rden) begin
            rom_q <= rom[rom_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic fl, input logic ld,
                                 input logic [7:0] ld_val, input int cycles);
        instr_ready = rdy;
        flush       = fl;
        pc_load     = ld;
        pc_load_val = ld_val;
        stepCycle();
        flush   = 1'b0;
        pc_load = 1'b0;
        for (int i = 1; i < cycles; i++) begin
            stepCycle();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_inc_en"},      inc_en,      0);
        checkOutput({tag, "_rom_rden"},    rom_rden,    0);
        checkOutput({tag, "_instr_valid"}, instr_valid, 0);
        checkOutput({tag, "_instr"},       instr,       0);
        checkOutput({tag, "_instr_pc"},    instr_pc,    0);
        checkOutput({tag, "_halted"},      halted,      0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput({tag, "_stall_cnt"},   stall_cnt,   0);
`endif
    endtask

    task automatic clearModel();
        sb.delete();
        halt_issued = 1'b0;
        halt_age    = 0;
        prev_stall  = 1'b0;
    endtask

    // Monitor: pushes an expectation for each issued read, pops on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            if (halt_issued) begin
                halt_age++;
            end
            checkOutput("halted", halted, (halt_issued && halt_age >= 2));
            checkOutput("rom_addr", rom_addr, pc);
            checkOutput("rden_vs_inc", rom_rden, inc_en);
            if (prev_stall) begin
                checkOutput("hold_valid", instr_valid, 1);
                checkOutput("hold_instr", instr, prev_word);
                checkOutput("hold_pc", instr_pc, prev_pc);
            end
            if (flush) begin
                checkOutput("rden_in_flush", rom_rden, 0);
                clearModel();
            end else begin
                if (instr_valid && instr_ready) begin
                    checkOutput("sb_pending", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        logic [39:0] exp_entry;
                        exp_entry = sb.pop_front();
                        checkOutput("instr", instr, exp_entry[39:8]);
                        checkOutput("instr_pc", instr_pc, exp_entry[7:0]);
                    end
                end
                if (halt_issued && halt_age >= 2) begin
                    checkOutput("no_read_after_halt", rom_rden, 0);
                end
                if (rom_rden && !halt_issued) begin
                    logic [31:0] word;
                    word = rom[pc];
                    sb.push_back({word, pc});
                    if (word[31:26] == 6'h3F) begin
                        halt_issued = 1'b1;
                        halt_age    = 0;
                    end
                end
                prev_stall = instr_valid && !instr_ready;
                prev_word  = instr;
                prev_pc    = instr_pc;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 32'h1000_0000 + i;
        end
        clearModel();
        reset       = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h00;
        #1;
        checkResetValues("reset");
        stepCycle();
        stepCycle();
        pc_load = 1'b0;
        stepCycle();
        checkResetValues("reset_held");

        // Release: read issues in cycle 0, first word valid in cycle 2, then one per cycle.
        reset = 1'b1;
        #1;
        checkOutput("inc_en_c0", inc_en, 1);
        checkOutput("valid_c0", instr_valid, 0);
        stepCycle();
        checkOutput("valid_c1", instr_valid, 0);
        stepCycle();
        checkOutput("valid_c2", instr_valid, 1);
        checkOutput("first_pc", instr_pc, 8'h00);
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            checkOutput("throughput_valid", instr_valid, 1);
        end

        // Back-pressure: buffer fills, reads stop, contents hold.
        instr_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            stepCycle();
            checkOutput("stall_inc_en", inc_en, 0);
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("stall_cnt_7", stall_cnt, 7);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4);

        // Flush while streaming, then while full; new stream starts at the reloaded pc.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h40, 1);
        checkOutput("valid_after_flush_run", instr_valid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h20, 1);
        checkOutput("valid_after_flush_full", instr_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("stall_cnt_kept", (stall_cnt >= 16'd7), 1);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5);

        // Halt word at address 3.
        rom[3] = 32'hFC00_0000;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 12);
        checkOutput("halt_state", halted, 1);
        checkOutput("halt_drained", instr_valid, 0);
        checkOutput("halt_no_inc", inc_en, 0);
        checkOutput("halt_sb_empty", sb.size(), 0);

        // Flush leaves HALT; then reset mid-fetch clears everything asynchronously.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 1);
        checkOutput("flush_exits_halt", halted, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 3);
        reset = 1'b0;
        #1;
        clearModel();
        checkResetValues("async_reset");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE, 2);
        reset = 1'b1;
        #1;
        checkOutput("wrap_first_issue", rom_addr, 8'hFE);
        stepCycle();
        stepCycle();
        checkOutput("wrap_first_pc", instr_pc, 8'hFE);
        for (int i = 0; i < 10; i++) begin
            stepCycle();
        end
        checkOutput("wrap_halted", halted, 1);
        checkOutput("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
